// File: rtl/vram_arbiter_pkg.sv
// Shared graphic-card definitions: framebuffer geometry defaults and the
// owner tag that travels alongside each RAM access.
package vram_arbiter_pkg;

    localparam int GFX_ADDR_WIDTH = 13;
    localparam int GFX_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VGA  = 2'd1,
        OWN_HRD  = 2'd2,
        OWN_HWR  = 2'd3
    } owner_t;

endpackage

// File: rtl/vram_arbiter.sv
// Single-port framebuffer arbiter: VGA scanout has priority, the host port gets
// a forced grant after STARVE_LIMIT blocked cycles. Reads return two cycles after grant.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = GFX_ADDR_WIDTH,
    parameter int DATA_WIDTH   = GFX_DATA_WIDTH,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  VgaReq,
    input  logic [ADDR_WIDTH-1:0] VgaAddr,
    output logic                  VgaGnt,
    output logic                  VgaRdValid,
    output logic [DATA_WIDTH-1:0] VgaRdData,
    input  logic                  HostReq,
    input  logic                  HostWe,
    input  logic [ADDR_WIDTH-1:0] HostAddr,
    input  logic [DATA_WIDTH-1:0] HostWData,
    output logic                  HostGnt,
    output logic                  HostRdValid,
    output logic [DATA_WIDTH-1:0] HostRdData,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic                  MemWe,
    output logic [DATA_WIDTH-1:0] MemWData,
    input  logic [DATA_WIDTH-1:0] MemRData,
    output logic [15:0]           StallCount
);

    localparam int WC_W = $clog2(STARVE_LIMIT + 1);

    logic [WC_W-1:0]       r_wait_cnt;
    logic [15:0]           r_stall_cnt;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_mem_we;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    owner_t                r_s1;
    owner_t                r_s2;

    logic   w_force_host;
    logic   w_vga_gnt;
    logic   w_host_gnt;
    logic   w_host_stall;
    owner_t w_tag;

    // Grants look only at requests and the wait counter, never at Mem*.
    assign w_force_host = HostReq && (r_wait_cnt == WC_W'(STARVE_LIMIT));
    assign w_vga_gnt    = VgaReq && !w_force_host;
    assign w_host_gnt   = HostReq && !w_vga_gnt;
    assign w_host_stall = HostReq && !w_host_gnt;

    always_comb begin
        w_tag = OWN_NONE;
        if (w_vga_gnt)
            w_tag = OWN_VGA;
        else if (w_host_gnt)
            w_tag = HostWe ? OWN_HWR : OWN_HRD;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_s1        <= OWN_NONE;
            r_s2        <= OWN_NONE;
        end else begin
            r_mem_we <= w_host_gnt && HostWe;
            if (w_vga_gnt) begin
                r_mem_addr <= VgaAddr;
            end else if (w_host_gnt) begin
                r_mem_addr  <= HostAddr;
                r_mem_wdata <= HostWData;
            end
            r_s1 <= w_tag;
            r_s2 <= r_s1;
        end
    end

    // A blocked cycle can never occur at the limit (it would force a grant),
    // so the increment cannot overshoot STARVE_LIMIT.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_host_stall)
                r_wait_cnt <= r_wait_cnt + WC_W'(1);
            else
                r_wait_cnt <= '0;
            if (w_host_stall && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign VgaGnt      = w_vga_gnt;
    assign HostGnt     = w_host_gnt;
    assign VgaRdValid  = (r_s2 == OWN_VGA);
    assign HostRdValid = (r_s2 == OWN_HRD);
    assign VgaRdData   = MemRData;
    assign HostRdData  = MemRData;
    assign MemAddr     = r_mem_addr;
    assign MemWe       = r_mem_we;
    assign MemWData    = r_mem_wdata;
    assign StallCount  = r_stall_cnt;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus random traffic checked against
// a transaction-level model (shadow memory + expected-completion queue).
module tb_vram_arbiter;

    localparam int AW    = 13;
    localparam int DW    = 8;
    localparam int LIMIT = 8;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          VgaReq, HostReq, HostWe;
    logic [AW-1:0] VgaAddr, HostAddr;
    logic [DW-1:0] HostWData;
    logic          VgaGnt, HostGnt, VgaRdValid, HostRdValid, MemWe;
    logic [DW-1:0] VgaRdData, HostRdData, MemWData, MemRData;
    logic [AW-1:0] MemAddr;
    logic [15:0]   StallCount;

    always #5 Clk = ~Clk;

    vram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) u_dut (
        .Clk(Clk), .Rst(Rst),
        .VgaReq(VgaReq), .VgaAddr(VgaAddr), .VgaGnt(VgaGnt),
        .VgaRdValid(VgaRdValid), .VgaRdData(VgaRdData),
        .HostReq(HostReq), .HostWe(HostWe), .HostAddr(HostAddr), .HostWData(HostWData),
        .HostGnt(HostGnt), .HostRdValid(HostRdValid), .HostRdData(HostRdData),
        .MemAddr(MemAddr), .MemWe(MemWe), .MemWData(MemWData), .MemRData(MemRData),
        .StallCount(StallCount)
    );

    // Second instance: host permanently blocked by VGA, huge starvation limit.
    logic          Rst2, VgaReq2, HostReq2, VgaGnt2, HostGnt2, VgaRdValid2, HostRdValid2, MemWe2;
    logic [AW-1:0] VgaAddr2, HostAddr2, MemAddr2;
    logic [DW-1:0] HostWData2, VgaRdData2, HostRdData2, MemWData2;
    logic [DW-1:0] MemRData2 = '0;
    logic          HostWe2 = 1'b0;
    logic [15:0]   StallCount2;

    vram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(70000)) u_dut_sat (
        .Clk(Clk), .Rst(Rst2),
        .VgaReq(VgaReq2), .VgaAddr(VgaAddr2), .VgaGnt(VgaGnt2),
        .VgaRdValid(VgaRdValid2), .VgaRdData(VgaRdData2),
        .HostReq(HostReq2), .HostWe(HostWe2), .HostAddr(HostAddr2), .HostWData(HostWData2),
        .HostGnt(HostGnt2), .HostRdValid(HostRdValid2), .HostRdData(HostRdData2),
        .MemAddr(MemAddr2), .MemWe(MemWe2), .MemWData(MemWData2), .MemRData(MemRData2),
        .StallCount(StallCount2)
    );

    // Behavioural synchronous RAM with a preload port.
    logic [DW-1:0] ram [0:8191];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    always @(posedge Clk) begin
        if (pl_en)
            ram[pl_addr] <= pl_data;
        else if (MemWe)
            ram[MemAddr] <= MemWData;
        MemRData <= ram[MemAddr];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Reference model state
    typedef struct {
        int            cyc;
        bit            to_vga;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           exp_q[$];
    logic [DW-1:0] smem [0:8191];
    int            cyc_n   = 0;
    int            m_wait  = 0;
    int            m_stall = 0;
    bit            m_we    = 0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wdata = '0;

    logic          s_vgnt, s_hgnt, s_vv, s_hv, s_we;
    logic [DW-1:0] s_vd, s_hd, s_wd;
    logic [AW-1:0] s_addr;
    logic [15:0]   s_stall;

    task automatic tick();
        bit e_force, e_vg, e_hg, e_vv, e_hv;
        @(negedge Clk);
        s_vgnt = VgaGnt;  s_hgnt = HostGnt;
        s_vv = VgaRdValid; s_hv = HostRdValid;
        s_vd = VgaRdData;  s_hd = HostRdData;
        s_we = MemWe; s_addr = MemAddr; s_wd = MemWData; s_stall = StallCount;
        if (Rst) begin
            check_val("rst_vvalid", 32'(s_vv), 0);
            check_val("rst_hvalid", 32'(s_hv), 0);
            check_val("rst_memwe", 32'(s_we), 0);
            exp_q.delete();
            m_wait = 0; m_stall = 0; m_we = 0; m_addr = '0; m_wdata = '0;
        end else begin
            e_force = HostReq && (m_wait == LIMIT);
            e_vg    = VgaReq && !e_force;
            e_hg    = HostReq && !e_vg;
            check_val("vgnt", 32'(s_vgnt), 32'(e_vg));
            check_val("hgnt", 32'(s_hgnt), 32'(e_hg));
            check_val("stall", 32'(s_stall), 32'(m_stall));
            check_val("memwe", 32'(s_we), 32'(m_we));
            check_val("memaddr", 32'(s_addr), 32'(m_addr));
            if (m_we)
                check_val("memwdata", 32'(s_wd), 32'(m_wdata));
            e_vv = 0; e_hv = 0;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc_n) begin
                e_vv = exp_q[0].to_vga;
                e_hv = !exp_q[0].to_vga;
                if (e_vv) check_val("vdata", 32'(s_vd), 32'(exp_q[0].data));
                else      check_val("hdata", 32'(s_hd), 32'(exp_q[0].data));
                void'(exp_q.pop_front());
            end
            check_val("vvalid", 32'(s_vv), 32'(e_vv));
            check_val("hvalid", 32'(s_hv), 32'(e_hv));
            m_we = 0;
            if (e_vg) begin
                exp_q.push_back('{cyc_n + 2, 1'b1, smem[VgaAddr]});
                m_addr = VgaAddr;
            end else if (e_hg) begin
                m_addr = HostAddr;
                if (HostWe) begin
                    smem[HostAddr] = HostWData;
                    m_we = 1; m_wdata = HostWData;
                end else begin
                    exp_q.push_back('{cyc_n + 2, 1'b0, smem[HostAddr]});
                end
            end
            if (HostReq && !e_hg) begin
                m_wait++;
                if (m_stall < 16'hFFFF) m_stall++;
            end else begin
                m_wait = 0;
            end
        end
        cyc_n++;
        @(posedge Clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d; smem[a] = d;
        @(posedge Clk);
        #1;
        pl_en = 1'b0;
    endtask

    bit s2_done = 0;
    bit s2_bad  = 0;

    // Saturation scenario runs concurrently with the main sequence.
    initial begin
        Rst2 = 1'b1; VgaReq2 = 1'b1; HostReq2 = 1'b1;
        VgaAddr2 = '0; HostAddr2 = '0; HostWData2 = '0;
        @(posedge Clk);
        #1;
        Rst2 = 1'b0;
        for (int k = 0; k <= 66000; k++) begin
            @(negedge Clk);
            if (HostGnt2 || !VgaGnt2 || MemWe2 || HostRdValid2) s2_bad = 1;
            if (k == 100 || k == 65534 || k == 65535 || k == 65536 || k == 66000)
                check_val($sformatf("sat_stall_k%0d", k), 32'(StallCount2),
                          (k > 65535) ? 32'hFFFF : 32'(k));
        end
        check_val("sat_host_blocked", 32'(s2_bad), 0);
        s2_done = 1;
    end

    initial begin
        int first_hg;
        Rst = 1'b1;
        VgaReq = 0; HostReq = 0; HostWe = 0;
        VgaAddr = '0; HostAddr = '0; HostWData = '0;
        #1;
        tick();
        check_val("rst_memaddr", 32'(s_addr), 0);
        check_val("rst_memwdata", 32'(s_wd), 0);
        check_val("rst_stall", 32'(s_stall), 0);
        check_val("rst_gnts", {30'd0, s_vgnt, s_hgnt}, 0);
        tick();
        Rst = 1'b0;

        for (int a = 0; a < 64; a++)
            preload(AW'(a), (a == 5) ? 8'hA5 : DW'($urandom));

        // Host read of preloaded word
        HostReq = 1; HostWe = 0; HostAddr = 13'h0005;
        tick();
        check_val("t1_hgnt", 32'(s_hgnt), 1);
        HostReq = 0;
        tick();
        check_val("t1_n1_hvalid", 32'(s_hv), 0);
        tick();
        check_val("t1_n2_hvalid", 32'(s_hv), 1);
        check_val("t1_n2_hdata", 32'(s_hd), 32'hA5);
        tick();
        check_val("t1_n3_hvalid", 32'(s_hv), 0);

        // Starvation: VGA hogs, host write forced through on 9th cycle
        VgaReq = 1; VgaAddr = 13'h0007;
        HostReq = 1; HostWe = 1; HostAddr = 13'h0010; HostWData = 8'h3C;
        first_hg = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (s_hgnt) begin
                first_hg = i;
                break;
            end
        end
        check_val("t2_first_hgnt", 32'(first_hg), 9);
        HostReq = 0;
        tick();
        check_val("t2_vgnt_after", 32'(s_vgnt), 1);
        check_val("t2_memwe", 32'(s_we), 1);
        check_val("t2_memaddr", 32'(s_addr), 32'h10);
        check_val("t2_memwdata", 32'(s_wd), 32'h3C);
        check_val("t2_stall", 32'(s_stall), 8);
        VgaReq = 0;
        tick(); tick(); tick();

        // Back-to-back write then read of the same address
        HostReq = 1; HostWe = 1; HostAddr = 13'h0020; HostWData = 8'h77;
        tick();
        HostWe = 0;
        tick();
        HostReq = 0;
        tick();
        tick();
        check_val("t3_hvalid", 32'(s_hv), 1);
        check_val("t3_hdata", 32'(s_hd), 32'h77);

        // Random mixed traffic
        for (int i = 0; i < 1000; i++) begin
            if (!VgaReq || s_vgnt || $urandom_range(0, 19) == 0) begin
                VgaReq  = ($urandom_range(0, 99) < 55);
                VgaAddr = AW'($urandom_range(0, 63));
            end
            if (!HostReq || s_hgnt || $urandom_range(0, 19) == 0) begin
                HostReq   = ($urandom_range(0, 99) < 55);
                HostWe    = ($urandom_range(0, 3) == 0);
                HostAddr  = AW'($urandom_range(0, 63));
                HostWData = DW'($urandom);
            end
            tick();
        end
        VgaReq = 0; HostReq = 0;
        tick(); tick(); tick();
        check_val("rand_drained", 32'(exp_q.size()), 0);

        // Reset one cycle after a VGA grant
        VgaReq = 1; VgaAddr = 13'h0033;
        tick();
        check_val("t5_vgnt", 32'(s_vgnt), 1);
        VgaReq = 0;
        Rst = 1;
        tick();
        Rst = 0;
        tick();
        check_val("t5_vvalid_after_rst", 32'(s_vv), 0);
        check_val("t5_memwe_after_rst", 32'(s_we), 0);
        tick();
        check_val("t5_vvalid_late", 32'(s_vv), 0);
        VgaReq = 1; VgaAddr = 13'h0005;
        tick();
        VgaReq = 0;
        tick();
        tick();
        check_val("t5_post_vvalid", 32'(s_vv), 1);
        check_val("t5_post_vdata", 32'(s_vd), 32'(smem[5]));
        tick();

        for (int i = 0; i < 70000 && !s2_done; i++)
            @(posedge Clk);
        if (!s2_done)
            check_val("sat_timeout", 0, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port video-RAM arbiter for the graphic card. Shares one synchronous framebuffer RAM between the VGA scanout fetcher and the host port, which is driven by the UART command decoder. VGA reads have priority. A wait counter forces one host grant after bounded starvation. Read data returns through a fixed 2-cycle pipeline tagged with the owner.

## Interface
Parameters:
- ADDR_WIDTH, 13, framebuffer word-address width
- DATA_WIDTH, 8, framebuffer word width
- STARVE_LIMIT, 8, consecutive blocked host-request cycles before a forced host grant (≥1)

Ports:
- Clk  in  1  system clock, all logic on rising edge
- Rst  in  1  asynchronous, active-high reset
- VgaReq  in  1  VGA read request; held with VgaAddr until granted
- VgaAddr  in  ADDR_WIDTH  VGA read address
- VgaGnt  out  1  combinational accept of VgaReq this cycle
- VgaRdValid  out  1  VgaRdData valid, one-cycle pulse
- VgaRdData  out  DATA_WIDTH  read data (MemRData pass-through)
- HostReq  in  1  host request; held with HostWe/HostAddr/HostWData until granted
- HostWe  in  1  1 = write, 0 = read
- HostAddr  in  ADDR_WIDTH  host address
- HostWData  in  DATA_WIDTH  host write data
- HostGnt  out  1  combinational accept of HostReq this cycle
- HostRdValid  out  1  HostRdData valid, one-cycle pulse
- HostRdData  out  DATA_WIDTH  read data (MemRData pass-through)
- MemAddr  out  ADDR_WIDTH  registered RAM address
- MemWe  out  1  registered RAM write enable
- MemWData  out  DATA_WIDTH  registered RAM write data
- MemRData  in  DATA_WIDTH  RAM read data, valid the cycle after its address is presented
- StallCount  out  16  saturating total of cycles with HostReq high and HostGnt low

## Operation
- At most one grant per cycle. No idle bubbles: a pending request is granted every cycle.
- Priority: forced-host if WaitCnt == STARVE_LIMIT and HostReq, else VGA if VgaReq, else host if HostReq.
- WaitCnt: +1 each cycle with HostReq high and HostGnt low; cleared on HostGnt or when HostReq is low; never exceeds STARVE_LIMIT.
- A forced grant costs VGA one cycle. VgaReq stays pending and VGA wins the next cycle, because WaitCnt is then 0.
- On grant in cycle N, Mem* is registered at the end of N. For a write, MemWe=1 with HostWData for exactly cycle N+1. For a read, MemWe=0.
- Owner pipeline: tag S1 ∈ {NONE, VGA, HRD, HWR} registered at end of N; S2 = S1 one cycle later.
- In cycle N+2: VgaRdValid = (S2 == VGA) and HostRdValid = (S2 == HRD). Both data outputs always show MemRData.
- With no grant, MemWe=0 and MemAddr/MemWData hold their last values.
- Host read-after-write to the same address, granted back-to-back, returns the new data. This relies on the RAM's write-then-read ordering; no forwarding is added.
- StallCount saturates at 0xFFFF and is cleared only by Rst.

## Timing
- Reset values: MemAddr=0, MemWe=0, MemWData=0, S1=S2=NONE, WaitCnt=0, StallCount=0, VgaRdValid=HostRdValid=0.
- Gnt outputs depend only on Req inputs and WaitCnt, with no comb path from Mem*.
- Read latency: grant cycle N → RdValid in cycle N+2. Throughput is 1 access/cycle, sustained.
- Write latency: grant N → MemWe in N+1.
- Simultaneous requests with WaitCnt < STARVE_LIMIT: VgaGnt=1, HostGnt=0.
- Reset mid-operation: in-flight tags are cleared and no RdValid follows. A write registered but not yet presented is dropped (MemWe forced 0).
- A requester dropping Req before Gnt is legal. Its request is simply withdrawn and WaitCnt clears.

## Structure
- The shared graphic-card package holds:
  - the owner-tag enum (NONE, VGA, HRD, HWR)
  - the default ADDR_WIDTH/DATA_WIDTH, so the VGA fetcher, UART decoder and this block agree.
- Single module; no sub-module is warranted. The wait counter, StallCount and the 2-stage tag pipe stay inline.

## Test plan
- Reset → all outputs 0. A HostReq read of addr 0x0005, preloaded 0xA5, is granted cycle N. Expect HostRdValid=1 with HostRdData=0xA5 at N+2 only.
- VgaReq held high continuously and HostReq write 0x0010←0x3C held: HostGnt is first asserted on the 9th cycle (WaitCnt reaches 8). MemWe=1 at addr 0x0010 the following cycle, and VGA is granted again the next cycle. StallCount=8.
- Back-to-back host write 0x0020←0x77 then read 0x0020 → HostRdValid two cycles after the read grant with data 0x77.
- Alternating VgaReq/HostReq reads on a seeded RAM: every RdValid is routed to the correct owner with the correct data, and there are no dropped or duplicated pulses over 1000 random cycles.
- Assert Rst one cycle after a VGA read grant → no VgaRdValid afterwards and MemWe stays 0. The first post-reset grant behaves normally.
- HostReq blocked by VGA for 70000 cycles with STARVE_LIMIT set to 65535+ via parameter → StallCount saturates at 0xFFFF.
